// File: rtl/seq_alu.sv
// Registered sequential ALU: single-cycle logic/shift/add ops, Booth multiply, non-restoring divide.
// Optional divider datapath is enabled with `define SEQ_ALU_DIV_EN.
module seq_alu #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [4:0]         op_code,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] c,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic               div_zero
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [4:0] OP_DIV  = 5'b10000;
`endif
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHW-1:0]   LAST    = SHW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, FIX} state_t;
  state_t state;

  logic [4:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [SHW-1:0]   cnt;

  // Handshake: start is taken only in IDLE and not in the cycle done is high.
  logic accept;
  assign accept = (state == IDLE) && start && !done;

  // Single-cycle datapath works from the latched operands.
  logic [WIDTH-1:0] sum, diff, neg_b;
  logic [SHW-1:0]   amt, amt_n;
  logic             big;
  logic [WIDTH-1:0] exec_lo, exec_hi;
  logic             exec_ovf, exec_dz;

  assign sum   = a_r + b_r;
  assign diff  = a_r - b_r;
  assign neg_b = -b_r;
  assign amt   = b_r[SHW-1:0];
  assign amt_n = -amt;
  assign big   = |b_r[WIDTH-1:SHW];

  always_comb begin
    exec_lo  = '0;
    exec_hi  = '0;
    exec_ovf = 1'b0;
    exec_dz  = 1'b0;
    case (op_r)
      OP_ADD: begin
        exec_lo  = sum;
        exec_ovf = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SUB: begin
        exec_lo  = diff;
        exec_ovf = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_AND:  exec_lo = a_r & b_r;
      OP_OR:   exec_lo = a_r | b_r;
      OP_SHR:  exec_lo = big ? '0 : (a_r >> amt);
      OP_SHRA: exec_lo = big ? {WIDTH{a_r[WIDTH-1]}} : WIDTH'($signed(a_r) >>> amt);
      OP_SHL:  exec_lo = big ? '0 : (a_r << amt);
      OP_ROR:  exec_lo = (a_r >> amt) | (a_r << amt_n);
      OP_ROL:  exec_lo = (a_r << amt) | (a_r >> amt_n);
      OP_NEG: begin
        exec_lo  = neg_b;
        exec_ovf = (b_r == MIN_VAL);
      end
      OP_NOT:  exec_lo = ~b_r;
`ifdef SEQ_ALU_DIV_EN
      // Only zero divisors reach EXEC for a divide.
      OP_DIV: begin
        exec_lo = '1;
        exec_hi = a_r;
        exec_dz = 1'b1;
      end
`endif
      default: exec_lo = '0;
    endcase
  end

  // Booth step: acc:mq:mq1 shifts right arithmetically once per cycle.
  logic [WIDTH:0]   acc, acc_add, m_ext;
  logic [WIDTH-1:0] mq;
  logic             mq1;

  assign m_ext = {b_r[WIDTH-1], b_r};

  always_comb begin
    acc_add = acc;
    case ({mq[0], mq1})
      2'b01:   acc_add = acc + m_ext;
      2'b10:   acc_add = acc - m_ext;
      default: acc_add = acc;
    endcase
  end

`ifdef SEQ_ALU_DIV_EN
  // Non-restoring divide on magnitudes; signs are restored in FIX.
  logic [WIDTH+1:0] rem, rem_sh, rem_nxt;
  logic [WIDTH-1:0] quo, dvs, rem_fix, q_signed, r_signed;

  assign rem_sh   = {rem[WIDTH:0], quo[WIDTH-1]};
  assign rem_nxt  = rem[WIDTH+1] ? rem_sh + {2'b00, dvs} : rem_sh - {2'b00, dvs};
  assign rem_fix  = rem[WIDTH+1] ? rem[WIDTH-1:0] + dvs : rem[WIDTH-1:0];
  assign q_signed = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) ? -quo : quo;
  assign r_signed = a_r[WIDTH-1] ? -rem_fix : rem_fix;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      cnt      <= '0;
      acc      <= '0;
      mq       <= '0;
      mq1      <= 1'b0;
      c        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            a_r  <= a;
            b_r  <= b;
            op_r <= op_code;
            cnt  <= '0;
            acc  <= '0;
            mq   <= a;
            mq1  <= 1'b0;
            busy <= 1'b1;
            if (op_code == OP_MUL) begin
              state <= MUL;
`ifdef SEQ_ALU_DIV_EN
            end else if (op_code == OP_DIV && b != '0) begin
              state <= DIV;
              rem   <= '0;
              quo   <= a[WIDTH-1] ? -a : a;
              dvs   <= b[WIDTH-1] ? -b : b;
`endif
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          c        <= {exec_hi, exec_lo};
          overflow <= exec_ovf;
          div_zero <= exec_dz;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        MUL: begin
          acc <= {acc_add[WIDTH], acc_add[WIDTH:1]};
          mq  <= {acc_add[0], mq[WIDTH-1:1]};
          mq1 <= mq[0];
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            c        <= {acc_add, mq[WIDTH-1:1]};
            overflow <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
`ifdef SEQ_ALU_DIV_EN
        DIV: begin
          rem <= rem_nxt;
          quo <= {quo[WIDTH-2:0], ~rem_nxt[WIDTH+1]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          c        <= {r_signed, q_signed};
          overflow <= (a_r == MIN_VAL) && (b_r == '1);
          div_zero <= 1'b0;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
`endif
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=32): directed vectors plus random ops scored against an arithmetic model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [4:0]  op_code;
  logic [31:0] a, b;
  logic [63:0] c;
  logic        busy, done, overflow, div_zero;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int active_start = -1;
  logic [63:0] last_c = '0;

  logic [65:0] exp_q[$];
  int          exp_edge_q[$];

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .start(start), .op_code(op_code), .a(a), .b(b),
    .c(c), .busy(busy), .done(done), .overflow(overflow), .div_zero(div_zero)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Reference model: expected {overflow, div_zero, c} and latency from plain signed arithmetic.
  function automatic void model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [63:0] ec, output logic eo, output logic ez, output int lat);
    longint sx, sy, r, q, rm;
    logic [31:0] t;
    sx = $signed(x);
    sy = $signed(y);
    ec = '0; eo = 1'b0; ez = 1'b0; lat = 1;
    t = x;
    case (op)
      5'b00011: begin r = sx + sy; ec = {32'd0, r[31:0]}; eo = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      5'b00100: begin r = sx - sy; ec = {32'd0, r[31:0]}; eo = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      5'b00101: ec = {32'd0, x & y};
      5'b00110: ec = {32'd0, x | y};
      5'b00111: ec = (y >= 32) ? 64'd0 : {32'd0, x >> y};
      5'b01000: begin
        if (y >= 32) t = x[31] ? 32'hFFFFFFFF : 32'h0;
        else begin r = sx >>> y; t = r[31:0]; end
        ec = {32'd0, t};
      end
      5'b01001: ec = (y >= 32) ? 64'd0 : {32'd0, x << y};
      5'b01010: begin for (int i = 0; i < int'(y % 32); i++) t = {t[0], t[31:1]}; ec = {32'd0, t}; end
      5'b01011: begin for (int i = 0; i < int'(y % 32); i++) t = {t[30:0], t[31]}; ec = {32'd0, t}; end
      5'b10001: begin r = -sy; ec = {32'd0, r[31:0]}; eo = (r > 64'sd2147483647); end
      5'b10010: ec = {32'd0, ~y};
      5'b01111: begin r = sx * sy; ec = r; lat = 32; end
`ifdef SEQ_ALU_DIV_EN
      5'b10000: begin
        if (y == 0) begin
          ec = {x, 32'hFFFFFFFF}; ez = 1'b1; lat = 1;
        end else begin
          q = sx / sy; rm = sx % sy;
          ec = {rm[31:0], q[31:0]};
          eo = (sx == -64'sd2147483648) && (sy == -64'sd1);
          lat = 33;
        end
      end
`endif
      default: ec = '0;
    endcase
  endfunction

  // driver tasks (called on a falling edge)
  task automatic launch(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ec;
    logic eo, ez;
    int lat;
    model(op, x, y, ec, eo, ez, lat);
    exp_q.push_back({eo, ez, ec});
    exp_edge_q.push_back(cycle + 1 + lat);
    active_start = cycle + 1;
    op_code = op; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL timeout: done not seen within 200 cycles, expected a pulse");
      exp_q.delete(); exp_edge_q.delete(); active_start = -1;
    end
    @(negedge clk);
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    launch(op, x, y);
    wait_done();
  endtask

  // scoreboard: compares every done pulse and watches busy each cycle
  always @(negedge clk) begin
    logic [65:0] e;
    int ed;
    if (!clr) begin
      check("done_busy", {63'd0, done & busy}, 64'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_done: got done=1 expected no pulse");
        end else begin
          e  = exp_q.pop_front();
          ed = exp_edge_q.pop_front();
          check("c", c, e[63:0]);
          check("overflow", {63'd0, overflow}, {63'd0, e[65]});
          check("div_zero", {63'd0, div_zero}, {63'd0, e[64]});
          check("latency", 64'(cycle), 64'(ed));
          last_c = e[63:0];
          active_start = -1;
        end
      end else if (active_start >= 0 && cycle >= active_start) begin
        check("busy_high", {63'd0, busy}, 64'd1);
      end else if (active_start < 0) begin
        check("busy_low", {63'd0, busy}, 64'd0);
      end
    end
  end

  logic [4:0] op_tab [14] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                               5'b01010, 5'b01011, 5'b10001, 5'b10010, 5'b01111, 5'b10000, 5'b00000};
  logic [31:0] edge_tab [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    int k, mode;

    clr = 1'b1; start = 1'b0; op_code = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_c", c, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_overflow", {63'd0, overflow}, 64'd0);
    check("reset_div_zero", {63'd0, div_zero}, 64'd0);
    clr = 1'b0;
    @(negedge clk);

    // directed vectors with literal expectations
    run_op(5'b00011, 32'h7FFFFFFF, 32'h1);
    check("add_lit_c", c, 64'h00000000_80000000);
    check("add_lit_ovf", {63'd0, overflow}, 64'd1);
    run_op(5'b01010, 32'h1, 32'd1);
    check("ror_lit", c, 64'h00000000_80000000);
    run_op(5'b01011, 32'h1, 32'd33);
    check("rol_lit", c, 64'h00000000_00000002);
    run_op(5'b01000, 32'h80000000, 32'd4);
    check("shra_lit", c, 64'h00000000_F8000000);
    run_op(5'b00111, 32'hFFFFFFFF, 32'd40);
    check("shr_lit", c, 64'd0);
    run_op(5'b01000, 32'h80000000, 32'd32);
    check("shra_big_lit", c, 64'h00000000_FFFFFFFF);
    run_op(5'b10001, 32'h80000000, 32'h80000000);
    check("neg_min_ovf", {63'd0, overflow}, 64'd1);
    run_op(5'b00100, 32'h80000000, 32'h1);
    check("sub_lit_c", c, 64'h00000000_7FFFFFFF);
    check("sub_lit_ovf", {63'd0, overflow}, 64'd1);

    // multiply with an ignored start part-way through
    launch(5'b01111, 32'hFFFFFFF9, 32'h6);
    repeat (9) @(negedge clk);
    op_code = 5'b00011; a = 32'd1; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("c_hold_during_mul", c, last_c);
    wait_done();
    check("mul_lit", c, 64'hFFFFFFFF_FFFFFFD6);
    check("mul_lit_ovf", {63'd0, overflow}, 64'd0);

`ifdef SEQ_ALU_DIV_EN
    run_op(5'b10000, 32'hFFFFFFEF, 32'h5);
    check("div_lit", c, 64'hFFFFFFFE_FFFFFFFD);
    run_op(5'b10000, 32'hFFFFFFEF, 32'h0);
    check("div0_lit", c, 64'hFFFFFFEF_FFFFFFFF);
    check("div0_flag", {63'd0, div_zero}, 64'd1);
    run_op(5'b10000, 32'h80000000, 32'hFFFFFFFF);
    check("div_minneg_lit", c, 64'h00000000_80000000);
    check("div_minneg_ovf", {63'd0, overflow}, 64'd1);
    launch(5'b10000, 32'hFFFFFFEF, 32'h5);
`else
    run_op(5'b10000, 32'hFFFFFFEF, 32'h5);
    check("div_off_lit", c, 64'd0);
    launch(5'b01111, 32'h12345678, 32'h9);
`endif

    // reset in the middle of a multicycle op
    repeat (14) @(negedge clk);
    clr = 1'b1;
    #1;
    check("clr_c", c, 64'd0);
    check("clr_busy", {63'd0, busy}, 64'd0);
    check("clr_done", {63'd0, done}, 64'd0);
    exp_q.delete(); exp_edge_q.delete(); active_start = -1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    repeat (40) @(negedge clk);
    run_op(5'b00011, 32'd2, 32'd3);
    check("add_after_clr", c, 64'd5);

    // random stimulus scored by the model
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 13);
      rop = (k == 13) ? 5'($urandom_range(0, 31)) : op_tab[k];
      mode = $urandom_range(0, 3);
      ra = $urandom;
      rb = $urandom;
      if (mode == 1) rb = $urandom_range(0, 40);
      if (mode == 2) begin ra = edge_tab[$urandom_range(0, 4)]; rb = edge_tab[$urandom_range(0, 4)]; end
      if (mode == 3) begin ra = edge_tab[$urandom_range(0, 4)]; rb = $urandom_range(0, 40); end
      run_op(rop, ra, rb);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
